// File: rtl/rv_sdram_bridge.sv
// rv_sdram_bridge
//   Splits the RISC-V core's 32-bit valid/ready memory access into one or two
//   16-bit half-word requests on the SDRAM arbiter's toggle-handshake port,
//   and gathers read halves back into a 32-bit word.
//
//   Optional build macro: RV_SDRAM_BRIDGE_STATS_EN adds request/wait/transfer
//   counters (o_stat_reqs, o_stat_wait, o_stat_xfers).
//
// Ports
//   i_clk, i_resetn      clock, synchronous active-low reset
//   i_mem_valid/addr/wdata/wstrb   CPU request (held until o_mem_ready)
//   o_mem_ready, o_mem_rdata        one-cycle completion pulse, read word
//   o_rv_addr/word/wdata/ds/wstrb   half-word request fields to the arbiter
//   o_rv_req, i_rv_req_ack          toggle handshake (req != ack = outstanding)
//   i_rv_dout                       read half-word, valid when ack matches req
module rv_sdram_bridge #(
  parameter int ADDR_WIDTH      = 23,
  parameter bit SKIP_EMPTY_HALF = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_mem_valid,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [31:0]           i_mem_wdata,
  input  logic [3:0]            i_mem_wstrb,
  output logic                  o_mem_ready,
  output logic [31:0]           o_mem_rdata,
  output logic [ADDR_WIDTH-1:0] o_rv_addr,
  output logic                  o_rv_word,
  output logic [31:0]           o_rv_wdata,
  output logic [1:0]            o_rv_ds,
  output logic [3:0]            o_rv_wstrb,
  output logic                  o_rv_req,
  input  logic                  i_rv_req_ack,
  input  logic [15:0]           i_rv_dout
`ifdef RV_SDRAM_BRIDGE_STATS_EN
  ,
  output logic [31:0]           o_stat_reqs,
  output logic [31:0]           o_stat_wait,
  output logic [31:0]           o_stat_xfers
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LO_REQ  = 3'd1,
    LO_WAIT = 3'd2,
    HI_REQ  = 3'd3,
    HI_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_rv_req;
  logic                    r_rv_word;
  logic [1:0]              r_rv_ds;
  logic [ADDR_WIDTH-1:0]   r_rv_addr;
  logic [31:0]             r_rv_wdata;
  logic [3:0]              r_rv_wstrb;
  logic [15:0]             r_gather_lo;
  logic [31:0]             r_mem_rdata;

  logic                    w_outstanding;
  logic                    w_is_wr;
  logic                    w_toggle;
  logic                    w_lo_cap;
  logic                    w_hi_cap;
  logic                    w_ready;
  logic                    w_start_hi;
  logic                    w_skip_hi;

  // Word alignment is implied: the low address bits never reach the arbiter.
  logic                    w_unused_addr_lsb;
  assign w_unused_addr_lsb = &{1'b0, i_mem_addr[1:0]};

  assign w_outstanding = (r_rv_req != i_rv_req_ack);
  assign w_is_wr       = |r_rv_wstrb;

  // Write halves with no strobes can be skipped entirely.
  assign w_start_hi = SKIP_EMPTY_HALF && (|i_mem_wstrb) && (i_mem_wstrb[1:0] == 2'b00);
  assign w_skip_hi  = SKIP_EMPTY_HALF && w_is_wr && (r_rv_wstrb[3:2] == 2'b00);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_resetn) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_toggle = 1'b0;
    w_lo_cap = 1'b0;
    w_hi_cap = 1'b0;
    w_ready  = 1'b0;
    case (r_state)
      // Ready is only ever high in DONE, so a valid seen here is always new.
      IDLE: begin
        if (i_mem_valid) w_next = w_start_hi ? HI_REQ : LO_REQ;
      end
      // Toggle only when the previous request has been acknowledged.
      LO_REQ: begin
        if (!w_outstanding) begin
          w_toggle = 1'b1;
          w_next   = LO_WAIT;
        end
      end
      LO_WAIT: begin
        if (!w_outstanding) begin
          w_lo_cap = !w_is_wr;
          w_next   = w_skip_hi ? DONE : HI_REQ;
        end
      end
      HI_REQ: begin
        if (!w_outstanding) begin
          w_toggle = 1'b1;
          w_next   = HI_WAIT;
        end
      end
      HI_WAIT: begin
        if (!w_outstanding) begin
          w_hi_cap = !w_is_wr;
          w_next   = DONE;
        end
      end
      DONE: begin
        w_ready = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request fields / read gather
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_rv_req    <= 1'b0;
      r_rv_word   <= 1'b0;
      r_rv_ds     <= 2'b00;
      r_rv_addr   <= '0;
      r_rv_wdata  <= 32'd0;
      r_rv_wstrb  <= 4'd0;
      r_gather_lo <= 16'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      // Fields only change in IDLE, so they are stable across any request.
      if (r_state == IDLE && i_mem_valid) begin
        r_rv_addr  <= {i_mem_addr[ADDR_WIDTH-1:2], 2'b00};
        r_rv_wdata <= i_mem_wdata;
        r_rv_wstrb <= i_mem_wstrb;
      end
      if (w_toggle) begin
        r_rv_req  <= ~r_rv_req;
        r_rv_word <= (r_state == HI_REQ);
        if (!w_is_wr)               r_rv_ds <= 2'b11;
        else if (r_state == HI_REQ) r_rv_ds <= r_rv_wstrb[3:2];
        else                        r_rv_ds <= r_rv_wstrb[1:0];
      end
      // The low half is staged so the visible read word only changes at
      // completion of a read.
      if (w_lo_cap) r_gather_lo <= i_rv_dout;
      if (w_hi_cap) r_mem_rdata <= {i_rv_dout, r_gather_lo};
    end
  end

  assign o_mem_ready = w_ready;
  assign o_mem_rdata = r_mem_rdata;
  assign o_rv_addr   = r_rv_addr;
  assign o_rv_word   = r_rv_word;
  assign o_rv_wdata  = r_rv_wdata;
  assign o_rv_ds     = r_rv_ds;
  assign o_rv_wstrb  = r_rv_wstrb;
  assign o_rv_req    = r_rv_req;

`ifdef RV_SDRAM_BRIDGE_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters (wrap naturally)
  // ---------------------------------------------------------------------------
  logic [31:0] r_stat_reqs;
  logic [31:0] r_stat_wait;
  logic [31:0] r_stat_xfers;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_stat_reqs  <= 32'd0;
      r_stat_wait  <= 32'd0;
      r_stat_xfers <= 32'd0;
    end else begin
      if (w_toggle) r_stat_reqs <= r_stat_reqs + 32'd1;
      if ((r_state == LO_WAIT || r_state == HI_WAIT) && w_outstanding)
        r_stat_wait <= r_stat_wait + 32'd1;
      if (w_ready) r_stat_xfers <= r_stat_xfers + 32'd1;
    end
  end

  assign o_stat_reqs  = r_stat_reqs;
  assign o_stat_wait  = r_stat_wait;
  assign o_stat_xfers = r_stat_xfers;
`endif

endmodule

// File: tb/tb_rv_sdram_bridge.sv
`timescale 1ns/1ps
// Bench for rv_sdram_bridge. Two instances: index 0 skips empty write halves,
// index 1 always issues both halves. A shared arbiter model acknowledges each
// toggle after ack_n cycles and keeps a byte-addressed SDRAM image; a separate
// CPU-level reference image predicts read data.
module tb_rv_sdram_bridge;
  localparam int AW = 23;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic [1:0]    valid;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;

  logic [1:0]    ready;
  logic [31:0]   rdata   [2];
  logic [AW-1:0] rv_addr [2];
  logic [1:0]    rv_word;
  logic [31:0]   rv_wdata[2];
  logic [1:0]    rv_ds   [2];
  logic [3:0]    rv_wstrb[2];
  logic [1:0]    req;
  logic [1:0]    ack;
  logic [15:0]   dout    [2];

`ifdef RV_SDRAM_BRIDGE_STATS_EN
  logic [31:0]   st_reqs[2];
  logic [31:0]   st_wait[2];
  logic [31:0]   st_xfer[2];
`endif

  rv_sdram_bridge #(.ADDR_WIDTH(AW), .SKIP_EMPTY_HALF(1'b1)) u_dut (
    .i_clk(clk), .i_resetn(resetn), .i_mem_valid(valid[0]), .i_mem_addr(addr),
    .i_mem_wdata(wdata), .i_mem_wstrb(wstrb), .o_mem_ready(ready[0]),
    .o_mem_rdata(rdata[0]), .o_rv_addr(rv_addr[0]), .o_rv_word(rv_word[0]),
    .o_rv_wdata(rv_wdata[0]), .o_rv_ds(rv_ds[0]), .o_rv_wstrb(rv_wstrb[0]),
    .o_rv_req(req[0]), .i_rv_req_ack(ack[0]), .i_rv_dout(dout[0])
`ifdef RV_SDRAM_BRIDGE_STATS_EN
    , .o_stat_reqs(st_reqs[0]), .o_stat_wait(st_wait[0]), .o_stat_xfers(st_xfer[0])
`endif
  );

  rv_sdram_bridge #(.ADDR_WIDTH(AW), .SKIP_EMPTY_HALF(1'b0)) u_dut_noskip (
    .i_clk(clk), .i_resetn(resetn), .i_mem_valid(valid[1]), .i_mem_addr(addr),
    .i_mem_wdata(wdata), .i_mem_wstrb(wstrb), .o_mem_ready(ready[1]),
    .o_mem_rdata(rdata[1]), .o_rv_addr(rv_addr[1]), .o_rv_word(rv_word[1]),
    .o_rv_wdata(rv_wdata[1]), .o_rv_ds(rv_ds[1]), .o_rv_wstrb(rv_wstrb[1]),
    .o_rv_req(req[1]), .i_rv_req_ack(ack[1]), .i_rv_dout(dout[1])
`ifdef RV_SDRAM_BRIDGE_STATS_EN
    , .o_stat_reqs(st_reqs[1]), .o_stat_wait(st_wait[1]), .o_stat_xfers(st_xfer[1])
`endif
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Arbiter + SDRAM model. Request log entry: {sel, addr, word, ds, wstrb, wdata}
  // ---------------------------------------------------------------------------
  int           ack_n = 1;
  int           cnt [2];
  logic [1:0]   prev_req;
  int           proto_err  = 0;
  int           stable_err = 0;
  logic [62:0]  log_q[$];
  logic [61:0]  cur [2];
  logic [7:0]   sdm [int];
  logic [7:0]   refm[int];

  function automatic logic [7:0] sd_rd(input int k);
    return sdm.exists(k) ? sdm[k] : 8'h00;
  endfunction
  function automatic logic [7:0] ref_rd(input int k);
    return refm.exists(k) ? refm[k] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      ack      <= 2'b00;
      prev_req <= 2'b00;
      cnt[0]    = 0;
      cnt[1]    = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        int base;
        // a toggle while the previous one was still outstanding
        if (req[i] != prev_req[i] && prev_req[i] != ack[i]) proto_err++;
        prev_req[i] <= req[i];
        if (req[i] != ack[i]) begin
          if (cnt[i] == 0) begin
            cur[i] = {rv_addr[i], rv_word[i], rv_ds[i], rv_wstrb[i], rv_wdata[i]};
            log_q.push_back({i[0], cur[i]});
          end else if ({rv_addr[i], rv_word[i], rv_ds[i], rv_wstrb[i], rv_wdata[i]} !== cur[i]) begin
            stable_err++;
          end
          cnt[i]++;
          if (cnt[i] >= ack_n) begin
            cnt[i] = 0;
            ack[i] <= req[i];
            base = (i << 24) + int'(rv_addr[i]) + (rv_word[i] ? 2 : 0);
            if (rv_wstrb[i] != 4'd0) begin
              if (rv_ds[i][0]) sdm[base]     = rv_wdata[i][rv_word[i]*16 +: 8];
              if (rv_ds[i][1]) sdm[base + 1] = rv_wdata[i][rv_word[i]*16 + 8 +: 8];
            end else begin
              dout[i] <= {sd_rd(base + 1), sd_rd(base)};
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One CPU access; cyc = cycles from the edge sampling valid to the one
  // showing ready (bounded).
  // ---------------------------------------------------------------------------
  task automatic xfer(input int sel, input logic [AW-1:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input int n, output int cyc);
    ack_n = n;
    @(negedge clk);
    addr = a; wdata = wd; wstrb = st; valid[sel] = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!ready[sel] && cyc < 3000);
    valid[sel] = 1'b0;
    chk("ready_seen", ready[sel], 1'b1);
  endtask

  // Access plus full check against the reference rules.
  task automatic run(input int sel, input logic [AW-1:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input int n);
    logic [62:0] exp_q[$];
    logic [31:0] prev, exp_rd;
    logic [AW-1:0] wa;
    bit wr, sk;
    int cyc, base;
    wr   = (st != 4'd0);
    sk   = (sel == 0);
    wa   = {a[AW-1:2], 2'b00};
    prev = rdata[sel];
    log_q.delete();
    if (!wr || !sk || st[1:0] != 2'b00)
      exp_q.push_back({sel[0], wa, 1'b0, (wr ? st[1:0] : 2'b11), st, wd});
    if (!wr || !sk || st[3:2] != 2'b00)
      exp_q.push_back({sel[0], wa, 1'b1, (wr ? st[3:2] : 2'b11), st, wd});
    xfer(sel, a, wd, st, n, cyc);
    chk("latency", cyc, exp_q.size() * (n + 2) + 1);
    chk("nreq", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk("req_fields", log_q[i], exp_q[i]);
    base = (sel << 24) + int'(wa);
    if (wr) begin
      chk("rdata_kept", rdata[sel], prev);
      for (int b = 0; b < 4; b++) if (st[b]) refm[base + b] = wd[b*8 +: 8];
    end else begin
      exp_rd = {ref_rd(base + 3), ref_rd(base + 2), ref_rd(base + 1), ref_rd(base)};
      chk("rdata", rdata[sel], exp_rd);
    end
    @(posedge clk); #1;
    chk("ready_pulse", ready[sel], 1'b0);
  endtask

  task automatic chk_reset(input int sel);
    chk("rst_out", {ready[sel], rdata[sel], rv_addr[sel], rv_word[sel], rv_ds[sel],
                    rv_wstrb[sel], rv_wdata[sel], req[sel]}, '0);
  endtask

  initial begin
    int cyc, waitc;
    logic [3:0] st;
    resetn = 1'b0; valid = 2'b00; addr = '0; wdata = '0; wstrb = '0;
    dout[0] = 16'h0; dout[1] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk) resetn = 1'b1;

    // Directed read: 0x1234 low, 0xABCD high, N=3 -> ready at cycle 11
    sdm[32'h066000] = 8'h34; sdm[32'h066001] = 8'h12;
    sdm[32'h066002] = 8'hCD; sdm[32'h066003] = 8'hAB;
    refm[32'h066000] = 8'h34; refm[32'h066001] = 8'h12;
    refm[32'h066002] = 8'hCD; refm[32'h066003] = 8'hAB;
    run(0, 23'h066000, 32'h0, 4'b0000, 3);
    chk("read_word", rdata[0], 32'hABCD1234);

    // High-half-only write, then partial-strobe writes on both instances
    run(0, 23'h066004, 32'hCAFEBABE, 4'b1100, 2);
    chk("rdata_after_wr", rdata[0], 32'hABCD1234);
    run(0, 23'h066008, 32'h11223344, 4'b0001, 1);
    run(1, 23'h066008, 32'h11223344, 4'b0001, 1);
    run(0, 23'h066004, 32'h0, 4'b0000, 2);
    chk("wr_readback", rdata[0], 32'hCAFE0000);

    // Long stall: fields stable, no extra toggle
    stable_err = 0; proto_err = 0;
    run(0, 23'h066000, 32'h0, 4'b0000, 200);
    chk("stall_stable", stable_err, 0);
    chk("stall_proto", proto_err, 0);

    // Reset during HI_WAIT
    ack_n = 5;
    log_q.delete();
    @(negedge clk);
    addr = 23'h066000; wstrb = 4'd0; valid[0] = 1'b1;
    waitc = 0;
    while (log_q.size() < 2 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    chk("hi_issued", log_q.size(), 2);
    resetn = 1'b0; valid[0] = 1'b0;
    @(posedge clk); #1;
    chk_reset(0);
    @(posedge clk); #1;
    chk("no_ready_abort", ready[0], 1'b0);
    @(negedge clk) resetn = 1'b1;

    // Fresh reads after the abort (three back-to-back, N=2)
    for (int k = 0; k < 3; k++) run(0, 23'h066000 + 23'(4 * k), 32'h0, 4'b0000, 2);
    chk("post_abort_rd", rdata[0], {ref_rd(32'h06600B), ref_rd(32'h06600A),
                                    ref_rd(32'h066009), ref_rd(32'h066008)});
`ifdef RV_SDRAM_BRIDGE_STATS_EN
    chk("stat_reqs", st_reqs[0], 32'd6);
    chk("stat_xfers", st_xfer[0], 32'd3);
    chk("stat_wait", st_wait[0], 32'd12);
`endif

    // Random traffic across both instances
    stable_err = 0; proto_err = 0;
    for (int k = 0; k < 60; k++) begin
      int sel;
      sel = $urandom_range(0, 1);
      st  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      run(sel, 23'h010000 + 23'($urandom_range(0, 15) * 4) + 23'($urandom_range(0, 3)),
          $urandom, st, $urandom_range(1, 4));
    end
    chk("rand_stable", stable_err, 0);
    chk("rand_proto", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rv_sdram_bridge.md
Name: rv_sdram_bridge

Overview:
- Sits directly upstream of the SDRAM arbiter's IOSys RISC-V port.
- Converts the softcore's 32-bit valid/ready memory bus into one or two 16-bit toggle-handshake half-word requests (o_rv_req / i_rv_req_ack).
- Gathers read halves back into a 32-bit word and returns it with a one-cycle ready pulse.
- All RV traffic into SDRAM, including the WRAM window, passes through this block.

Parameters:
- ADDR_WIDTH, 23, byte-address width on both sides.
- SKIP_EMPTY_HALF, 1, when 1 a write half whose two strobe bits are 0 issues no SDRAM request.

Ports:
- i_clk  input  1  system clock
- i_resetn  input  1  synchronous active-low reset
- i_mem_valid  input  1  CPU request; held with all fields stable until o_mem_ready
- i_mem_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored
- i_mem_wdata  input  32  write data
- i_mem_wstrb  input  4  byte strobes; 0 = read
- o_mem_ready  output  1  one-cycle completion pulse
- o_mem_rdata  output  32  read data, valid when o_mem_ready=1
- o_rv_addr  output  ADDR_WIDTH  {latched addr[ADDR_WIDTH-1:2], 2'b00}
- o_rv_word  output  1  0 = low half-word, 1 = high half-word
- o_rv_wdata  output  32  latched write word; arbiter selects the half via o_rv_word
- o_rv_ds  output  2  byte enables of the current half (all 2'b11 on reads)
- o_rv_wstrb  output  4  latched strobes; nonzero = write
- o_rv_req  output  1  toggle request
- i_rv_req_ack  input  1  toggle acknowledge; equal to o_rv_req means idle/done
- i_rv_dout  input  16  read half-word, valid in the cycle ack becomes equal to req

Behaviour:
- Reset, when i_resetn=0 at a posedge:
  - state=IDLE
  - o_rv_req=0, o_mem_ready=0, o_mem_rdata=0
  - o_rv_addr=0, o_rv_word=0, o_rv_ds=0, o_rv_wstrb=0, o_rv_wdata=0
  - The arbiter's ack shares the same reset, so req==ack after reset.
- Reset mid-transaction aborts immediately. No ready is issued for the aborted access. The in-flight toggle is dropped.
- Handshake: a request is outstanding while o_rv_req != i_rv_req_ack. The bridge toggles o_rv_req only when none is outstanding. Address, word, ds, wdata and wstrb are held constant while a request is outstanding.
- FSM states: IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, DONE.
- IDLE: when i_mem_valid=1 and o_mem_ready=0, latch addr, wdata and wstrb.
  - Next state is LO_REQ, unless this is a write with wstrb[1:0]==0 and SKIP_EMPTY_HALF=1, in which case next state is HI_REQ.
- LO_REQ: set o_rv_word=0 and o_rv_ds = (write ? wstrb[1:0] : 2'b11). Toggle o_rv_req. Go to LO_WAIT.
- LO_WAIT: when i_rv_req_ack==o_rv_req:
  - On a read, capture i_rv_dout into rdata[15:0].
  - Next state is HI_REQ, unless this is a write with wstrb[3:2]==0 and SKIP_EMPTY_HALF=1, in which case next state is DONE.
- HI_REQ: set o_rv_word=1 and o_rv_ds = (write ? wstrb[3:2] : 2'b11). Toggle o_rv_req. Go to HI_WAIT.
- HI_WAIT: when ack matches, on a read capture i_rv_dout into rdata[31:16]. Go to DONE.
- DONE: o_mem_ready=1 for exactly this cycle. o_mem_rdata holds the gathered word. Return to IDLE.
  - o_mem_rdata keeps its value until the next read completes.
  - Write completions leave o_mem_rdata unchanged.
- Any stall length is allowed; there is no timeout.
- Latency with ack arriving N cycles after the toggle:
  - Read: ready 2N+5 cycles after valid is sampled.
  - One-half write: N+3 cycles.
- A request with wstrb=0 is always a read; both halves are issued.
- SKIP_EMPTY_HALF=0: every access issues both halves. A zero-strobe write half goes out with o_rv_ds=2'b00.
- The cycle after DONE is IDLE. If i_mem_valid is still high then, it is treated as a new request. The CPU must drop valid on ready.

Optional Feature:
- Macro: RV_SDRAM_BRIDGE_STATS_EN.
- With the macro defined, the block adds three outputs:
  - o_stat_reqs [31:0]: +1 per toggle of o_rv_req.
  - o_stat_wait [31:0]: +1 per cycle spent in LO_WAIT or HI_WAIT with a request outstanding.
  - o_stat_xfers [31:0]: +1 per o_mem_ready.
- All three counters are zeroed by reset and wrap modulo 2^32.
- Without the macro the ports and counters do not exist, and the behaviour is otherwise identical.

Test Plan:
- Read 0x066000, wstrb=0; the ack model returns 0x1234 (lo) then 0xABCD (hi) with N=3 -> exactly two toggles, o_rv_word 0 then 1, ds 2'b11 both times, o_mem_rdata=0xABCD1234, ready pulse at cycle 11.
- Write 0x066004, wdata=0xCAFEBABE, wstrb=4'b1100 -> a single request with o_rv_word=1 and ds=2'b11, o_rv_wstrb=4'b1100, one ready pulse, o_mem_rdata unchanged.
- Write with wstrb=4'b0001, SKIP_EMPTY_HALF=1 -> only the lo request, ds=2'b01. Repeat with SKIP_EMPTY_HALF=0 -> a second request with word=1 and ds=2'b00.
- Stall the ack for 200 cycles -> o_rv_* stable throughout, no second toggle, ready only after the ack arrives.
- Assert i_resetn=0 during HI_WAIT -> next cycle all outputs at reset values with no ready pulse; a fresh read afterwards completes correctly.
- With RV_SDRAM_BRIDGE_STATS_EN, three back-to-back reads with N=2 -> o_stat_reqs=6, o_stat_xfers=3, o_stat_wait=12.
